// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the I/D cache-to-main-memory arbiter.
package cpu_mem_pkg;

   localparam int MEM_ADDR_W      = 16;
   localparam int MEM_DATA_W      = 16;
   localparam int MEM_BLOCK_WORDS = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL_I  = 2'd1,
      FILL_D  = 2'd2,
      WRITE_D = 2'd3
   } arb_state_e;

   // Byte-offset bits inside a block of 16-bit words; also the counter width.
   function automatic int block_off_w(input int block_words);
      return $clog2(block_words) + 1;
   endfunction

   function automatic logic [MEM_ADDR_W-1:0] block_base(input logic [MEM_ADDR_W-1:0] addr,
                                                        input int block_words);
      logic [MEM_ADDR_W-1:0] mask;
      mask = (MEM_ADDR_W'(1) << block_off_w(block_words)) - MEM_ADDR_W'(1);
      return addr & ~mask;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Fixed-priority, non-preemptive arbiter sharing one pipelined memory between
// the I-cache fill path and the D-cache fill / write-through path.
module mem_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W      = MEM_ADDR_W,
   parameter int DATA_W      = MEM_DATA_W,
   parameter int BLOCK_WORDS = MEM_BLOCK_WORDS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_req,
   input  logic [ADDR_W-1:0]              i_addr,
   input  logic                           d_req,
   input  logic                           d_wr,
   input  logic [ADDR_W-1:0]              d_addr,
   input  logic [DATA_W-1:0]              d_wdata,
   output logic                           i_grant,
   output logic                           d_grant,
   output logic                           i_done,
   output logic                           d_done,
   output logic                           fill_valid,
   output logic [DATA_W-1:0]              fill_data,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
   output logic                           mem_en,
   output logic                           mem_wr,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [DATA_W-1:0]              mem_wdata,
   input  logic [DATA_W-1:0]              mem_rdata,
   input  logic                           mem_valid,
   output logic [1:0]                     dbg_state
);

   localparam int CNT_W  = block_off_w(BLOCK_WORDS);
   localparam int WORD_W = $clog2(BLOCK_WORDS);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

   // Handshake: a requester raises req and holds it; grant is a level for the
   // whole ownership, done is a one-cycle pulse, req drops the cycle after done.
   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  iss_cnt_q, iss_cnt_d;
   logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              in_fill;
   logic              issuing;
   logic              last_rx;

   assign in_fill = (state_q == FILL_I) || (state_q == FILL_D);
   assign issuing = in_fill && (iss_cnt_q != CNT_FULL);
   assign last_rx = in_fill && mem_valid && (rx_cnt_q == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (d_req) begin
               state_d = d_wr ? WRITE_D : FILL_D;
            end else if (i_req) begin
               state_d = FILL_I;
            end
         end
         FILL_I, FILL_D: begin
            if (last_rx) begin
               state_d = IDLE;
            end
         end
         WRITE_D: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counters and grant-time latches; the D side wins when both request.
   always_comb begin
      iss_cnt_d = iss_cnt_q;
      rx_cnt_d  = rx_cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      if (state_q == IDLE) begin
         iss_cnt_d = '0;
         rx_cnt_d  = '0;
         if (d_req) begin
            addr_d  = d_wr ? d_addr : block_base(d_addr, BLOCK_WORDS);
            wdata_d = d_wdata;
         end else if (i_req) begin
            addr_d = block_base(i_addr, BLOCK_WORDS);
         end
      end else if (in_fill) begin
         if (issuing) begin
            iss_cnt_d = iss_cnt_q + CNT_W'(1);
         end
         if (mem_valid) begin
            rx_cnt_d = last_rx ? '0 : rx_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_cnt_q <= '0;
         rx_cnt_q  <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         iss_cnt_q <= iss_cnt_d;
         rx_cnt_q  <= rx_cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end

   // Outputs decode registered state only; done and fill_* also see mem_valid
   // so completion lands on the same cycle as the last returned word.
   always_comb begin
      i_grant    = (state_q == FILL_I);
      d_grant    = (state_q == FILL_D) || (state_q == WRITE_D);
      mem_en     = issuing || (state_q == WRITE_D);
      mem_wr     = (state_q == WRITE_D);
      mem_addr   = '0;
      mem_wdata  = '0;
      if (state_q == WRITE_D) begin
         mem_addr  = addr_q;
         mem_wdata = wdata_q;
      end else if (issuing) begin
         mem_addr = addr_q + (ADDR_W'(iss_cnt_q) << 1);
      end
      fill_valid = in_fill && mem_valid;
      fill_data  = fill_valid ? mem_rdata : '0;
      fill_word  = in_fill ? rx_cnt_q[WORD_W-1:0] : '0;
      i_done     = (state_q == FILL_I) && last_rx;
      d_done     = ((state_q == FILL_D) && last_rx) || (state_q == WRITE_D);
      dbg_state  = state_q;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: default instance with a 4-cycle memory
// plus a small instance (4-word blocks, 1-cycle memory).
module tb_mem_arbiter;

   localparam int L   = 4;
   localparam int BW  = 8;
   localparam int SL  = 1;
   localparam int SBW = 4;

   logic        clk = 1'b0;
   logic        rst;
   int          checks = 0;
   int          failures = 0;

   // main instance
   logic        i_req, d_req, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic        i_grant, d_grant, i_done, d_done, fill_valid, mem_en, mem_wr, mem_valid;
   logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  fill_word;
   logic [1:0]  dbg_state;

   // small instance
   logic        s_i_req;
   logic [15:0] s_i_addr;
   logic        s_i_grant, s_d_grant, s_i_done, s_d_done, s_fill_valid, s_mem_en, s_mem_wr, s_mem_valid;
   logic [15:0] s_fill_data, s_mem_addr, s_mem_wdata, s_mem_rdata;
   logic [1:0]  s_fill_word;
   logic [1:0]  s_dbg_state;

   wire [59:0] main_outs = {i_grant, d_grant, i_done, d_done, fill_valid, mem_en, mem_wr,
                            mem_addr, mem_wdata, fill_data, fill_word, dbg_state};
   wire [58:0] s_outs = {s_i_grant, s_d_grant, s_i_done, s_d_done, s_fill_valid, s_mem_en, s_mem_wr,
                         s_mem_addr, s_mem_wdata, s_fill_data, s_fill_word, s_dbg_state};

   always #5 clk = ~clk;

   mem_arbiter u_dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .i_grant(i_grant), .d_grant(d_grant), .i_done(i_done), .d_done(d_done),
      .fill_valid(fill_valid), .fill_data(fill_data), .fill_word(fill_word),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid), .dbg_state(dbg_state)
   );

   mem_arbiter #(.BLOCK_WORDS(SBW)) u_small (
      .clk(clk), .rst(rst),
      .i_req(s_i_req), .i_addr(s_i_addr),
      .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
      .i_grant(s_i_grant), .d_grant(s_d_grant), .i_done(s_i_done), .d_done(s_d_done),
      .fill_valid(s_fill_valid), .fill_data(s_fill_data), .fill_word(s_fill_word),
      .mem_en(s_mem_en), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_rdata(s_mem_rdata), .mem_valid(s_mem_valid), .dbg_state(s_dbg_state)
   );

   // Memory models: fixed latency, responses are not flushed by rst.
   logic [15:0] store [logic [15:0]];
   logic [L-1:0] pipe_v = '0;
   logic [15:0]  pipe_d [L];
   logic         stray_v, s_stray, s_pv = 1'b0;
   logic [15:0]  stray_d, s_stray_d, s_pd;

   function automatic logic [15:0] pattern(input logic [15:0] a);
      return (a * 16'd7) ^ 16'h3C5A;
   endfunction

   function automatic logic [15:0] mem_read(input logic [15:0] a);
      return store.exists(a) ? store[a] : pattern(a);
   endfunction

   always @(posedge clk) begin
      pipe_v <= {mem_en && !mem_wr, pipe_v[L-1:1]};
      for (int k = 0; k < L - 1; k++) pipe_d[k] <= pipe_d[k+1];
      pipe_d[L-1] <= mem_read(mem_addr);
      if (mem_en && mem_wr) store[mem_addr] = mem_wdata;
      s_pv <= s_mem_en && !s_mem_wr;
      s_pd <= pattern(s_mem_addr);
   end

   assign mem_valid   = pipe_v[0] | stray_v;
   assign mem_rdata   = pipe_v[0] ? pipe_d[0] : stray_d;
   assign s_mem_valid = s_pv | s_stray;
   assign s_mem_rdata = s_pv ? s_pd : s_stray_d;

   // All tasks start and end at 1 time unit after a rising edge.
   task automatic test_reset();
      rst = 1'b1; i_req = 0; d_req = 0; d_wr = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
      s_i_req = 0; s_i_addr = 0;
      stray_v = 1'b1; stray_d = 16'hDEAD; s_stray = 1'b1; s_stray_d = 16'hBEEF;
      repeat (2) @(negedge clk);
      checks++;
      if (main_outs !== '0) begin
         failures++; $display("FAIL reset_main outs=%h expected 0", main_outs);
      end
      checks++;
      if (s_outs !== '0) begin
         failures++; $display("FAIL reset_small outs=%h expected 0", s_outs);
      end
      @(posedge clk); #1;
      rst = 1'b0; stray_v = 1'b0; s_stray = 1'b0;
      @(negedge clk);
      checks++;
      if (main_outs !== '0) begin
         failures++; $display("FAIL idle_after_reset outs=%h expected 0", main_outs);
      end
      @(posedge clk); #1;
   endtask

   // kind: 0 = I fill, 1 = D fill, 2 = D write-through
   task automatic test_single_txn(input int kind, input logic [15:0] addr,
                                  input logic [15:0] data, input string name);
      logic [15:0] exp_q [$];
      logic [15:0] base, exp_addr, exp_wdata, exp_d;
      logic [6:0]  exp_ctl;
      int          n, last_k;
      base = addr & 16'hFFF0;
      if (kind != 2)
         for (int w = 0; w < BW; w++) exp_q.push_back(mem_read(base + 16'(2 * w)));
      n      = (kind == 2) ? 2 : BW + L + 1;
      last_k = (kind == 2) ? 1 : BW + L;
      i_req = (kind == 0); d_req = (kind != 0); d_wr = (kind == 2);
      i_addr = addr; d_addr = addr; d_wdata = data;
      @(posedge clk); #1;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (kind == 2) begin
            exp_ctl   = (k == 1) ? 7'b0111010 : 7'b0;
            exp_addr  = (k == 1) ? addr : 16'h0;
            exp_wdata = (k == 1) ? data : 16'h0;
         end else begin
            exp_ctl = {(kind == 0) && (k <= BW + L), (kind == 1) && (k <= BW + L), k <= BW, 1'b0,
                       (kind == 0) && (k == BW + L), (kind == 1) && (k == BW + L),
                       (k > L) && (k <= BW + L)};
            exp_addr  = (k <= BW) ? base + 16'(2 * (k - 1)) : 16'h0;
            exp_wdata = 16'h0;
         end
         checks++;
         if ({i_grant, d_grant, mem_en, mem_wr, i_done, d_done, fill_valid} !== exp_ctl ||
             mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin
            failures++;
            $display("FAIL %s k=%0d ctl(ig,dg,en,wr,id,dd,fv)=%b addr=%h wdata=%h expected ctl=%b addr=%h wdata=%h",
                     name, k, {i_grant, d_grant, mem_en, mem_wr, i_done, d_done, fill_valid},
                     mem_addr, mem_wdata, exp_ctl, exp_addr, exp_wdata);
         end
         if (exp_ctl[0]) begin
            exp_d = exp_q.pop_front();
            checks++;
            if (fill_data !== exp_d || fill_word !== 3'(k - 1 - L)) begin
               failures++;
               $display("FAIL %s_data k=%0d data=%h word=%0d expected data=%h word=%0d",
                        name, k, fill_data, fill_word, exp_d, k - 1 - L);
            end
         end
         @(posedge clk); #1;
         if (k == last_k) begin i_req = 0; d_req = 0; d_wr = 0; end
      end
   endtask

   // D fill at 0x2000 with an I fill at 0x0300 raised in cycle raise_k (0 = together).
   task automatic test_two_requesters(input int raise_k, input string name);
      logic [15:0] exp_q [$];
      logic [15:0] exp_addr, exp_d;
      logic [6:0]  exp_ctl;
      int          dk, ik, wexp;
      for (int w = 0; w < BW; w++) exp_q.push_back(mem_read(16'h2000 + 16'(2 * w)));
      for (int w = 0; w < BW; w++) exp_q.push_back(mem_read(16'h0300 + 16'(2 * w)));
      d_req = 1; d_wr = 0; d_addr = 16'h2000; i_addr = 16'h0300; i_req = (raise_k == 0);
      @(posedge clk); #1;
      for (int k = 1; k <= 2 * (BW + L) + 2; k++) begin
         @(negedge clk);
         dk = k;
         ik = k - (BW + L + 1);
         exp_ctl = {ik >= 1 && ik <= BW + L, dk >= 1 && dk <= BW + L,
                    (dk >= 1 && dk <= BW) || (ik >= 1 && ik <= BW), 1'b0,
                    ik == BW + L, dk == BW + L,
                    (dk > L && dk <= BW + L) || (ik > L && ik <= BW + L)};
         exp_addr = (dk >= 1 && dk <= BW) ? 16'h2000 + 16'(2 * (dk - 1)) :
                    (ik >= 1 && ik <= BW) ? 16'h0300 + 16'(2 * (ik - 1)) : 16'h0;
         checks++;
         if ({i_grant, d_grant, mem_en, mem_wr, i_done, d_done, fill_valid} !== exp_ctl ||
             mem_addr !== exp_addr) begin
            failures++;
            $display("FAIL %s k=%0d ctl(ig,dg,en,wr,id,dd,fv)=%b addr=%h expected ctl=%b addr=%h",
                     name, k, {i_grant, d_grant, mem_en, mem_wr, i_done, d_done, fill_valid},
                     mem_addr, exp_ctl, exp_addr);
         end
         if (exp_ctl[0]) begin
            exp_d = exp_q.pop_front();
            wexp  = (dk <= BW + L) ? dk - 1 - L : ik - 1 - L;
            checks++;
            if (fill_data !== exp_d || fill_word !== 3'(wexp)) begin
               failures++;
               $display("FAIL %s_data k=%0d data=%h word=%0d expected data=%h word=%0d",
                        name, k, fill_data, fill_word, exp_d, wexp);
            end
         end
         @(posedge clk); #1;
         if (k + 1 == raise_k) i_req = 1;
         if (dk == BW + L) d_req = 0;
         if (ik == BW + L) i_req = 0;
      end
   endtask

   task automatic test_reset_mid_fill();
      int nfv = 0;
      i_req = 1; i_addr = 16'h0500;
      @(posedge clk); #1;
      for (int k = 1; k <= L + 3; k++) begin
         @(negedge clk);
         if (fill_valid) nfv++;
         if (k < L + 3) begin @(posedge clk); #1; end
      end
      checks++;
      if (nfv != 3 || fill_word !== 3'd2) begin
         failures++; $display("FAIL pre_reset_words count=%0d word=%0d expected count=3 word=2", nfv, fill_word);
      end
      #1 rst = 1'b1; i_req = 0;
      #1;
      checks++;
      if (main_outs !== '0) begin
         failures++; $display("FAIL reset_mid_fill outs=%h expected 0", main_outs);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (main_outs !== '0) begin
            failures++; $display("FAIL stale_after_reset cyc=%0d outs=%h mem_valid=%b expected 0", k, main_outs, mem_valid);
         end
         @(posedge clk); #1;
      end
      test_single_txn(0, 16'h0500, 16'h0, "refill_after_reset");
   endtask

   task automatic test_stray_idle();
      stray_v = 1'b1; stray_d = 16'h55AA;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (main_outs !== '0) begin
            failures++; $display("FAIL stray_idle_main outs=%h expected 0", main_outs);
         end
         @(posedge clk); #1;
      end
      stray_v = 1'b0;
   endtask

   task automatic test_small_config();
      logic [15:0] base, exp_addr, exp_d;
      logic [6:0]  exp_ctl;
      base = 16'h0100;
      s_i_req = 1; s_i_addr = 16'h0106;
      @(posedge clk); #1;
      for (int k = 1; k <= SBW + SL + 1; k++) begin
         @(negedge clk);
         exp_ctl  = {k <= SBW + SL, 1'b0, k <= SBW, 1'b0, k == SBW + SL, 1'b0, (k > SL) && (k <= SBW + SL)};
         exp_addr = (k <= SBW) ? base + 16'(2 * (k - 1)) : 16'h0;
         checks++;
         if ({s_i_grant, s_d_grant, s_mem_en, s_mem_wr, s_i_done, s_d_done, s_fill_valid} !== exp_ctl ||
             s_mem_addr !== exp_addr) begin
            failures++;
            $display("FAIL small k=%0d ctl=%b addr=%h expected ctl=%b addr=%h", k,
                     {s_i_grant, s_d_grant, s_mem_en, s_mem_wr, s_i_done, s_d_done, s_fill_valid},
                     s_mem_addr, exp_ctl, exp_addr);
         end
         if (exp_ctl[0]) begin
            exp_d = pattern(base + 16'(2 * (k - 1 - SL)));
            checks++;
            if (s_fill_data !== exp_d || s_fill_word !== 2'(k - 1 - SL)) begin
               failures++;
               $display("FAIL small_data k=%0d data=%h word=%0d expected data=%h word=%0d",
                        k, s_fill_data, s_fill_word, exp_d, k - 1 - SL);
            end
         end
         @(posedge clk); #1;
         if (k == SBW + SL) s_i_req = 0;
      end
      s_stray = 1'b1; s_stray_d = 16'h1357;
      @(negedge clk);
      checks++;
      if (s_outs !== '0) begin
         failures++; $display("FAIL small_stray outs=%h expected 0", s_outs);
      end
      @(posedge clk); #1;
      s_stray = 1'b0;
   endtask

   task automatic test_random();
      int          kind;
      logic [15:0] addr;
      for (int n = 0; n < 20; n++) begin
         kind = $urandom_range(0, 2);
         addr = {8'h00, 8'($urandom)};
         if (kind == 2) addr[0] = 1'b0;
         test_single_txn(kind, addr, 16'($urandom), "random");
      end
   endtask

   initial begin
      test_reset();
      test_single_txn(0, 16'h1234, 16'h0, "i_fill_1234");
      test_single_txn(2, 16'h0040, 16'hBEEF, "d_write_0040");
      test_two_requesters(0, "simultaneous");
      test_two_requesters(5, "no_preempt");
      test_reset_mid_fill();
      test_stray_idle();
      test_small_config();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule
